instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction memory. Holds the program counter and drives the memory address. Waits a fixed number of clocks for the slow combinational memory to settle, then captures the instruction into a valid/ready output register for the decode stage. Supports a branch/jump redirect that flushes the held instruction, and prefetches the next word while decode stalls.

---
 rtl/instr_fetch.sv | 99 +++++++++
 tb/tb_instr_fetch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, waits MEM_WAIT clocks for the memory word to settle,
// and presents it to decode through a valid/ready register with prefetch and redirect flush.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_instr,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] fetch_cnt
);
    localparam int unsigned CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT - 1);
    localparam logic [31:0] PC_RST = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      pc, pc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             settled;
    logic             handshake;
    logic             capture;

    // Next-state: redirect beats capture; a capture restarts the wait for the following word.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        settled   = (cnt == CNT_MAX);
        handshake = (state == VALID) && id_ready;
        if (redirect_en) begin
            state_nxt = FETCH;
            pc_nxt    = redirect_pc & 32'hFFFF_FFFC;
            cnt_nxt   = '0;
        end else if (settled && ((state == FETCH) || id_ready)) begin
            capture   = 1'b1;
            state_nxt = VALID;
            pc_nxt    = pc + 32'd4;
            cnt_nxt   = '0;
        end else begin
            if (handshake) begin
                state_nxt = FETCH;
            end
            if (!settled) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= PC_RST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Decode-facing payload only moves on capture, so it is stable through stalls and flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instr    <= '0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
        end else if (capture) begin
            id_instr    <= mem_instr;
            id_pc       <= pc;
            id_pc_plus4 <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
        end else if (handshake) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign id_valid = (state == VALID);
    assign mem_addr = pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, async reset and PC wrap checks,
// then randomized traffic against a cycle-level behavioural model.
module tb_instr_fetch;
    localparam int unsigned MW = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr, mem_instr;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr, id_pc, id_pc_plus4, fetch_cnt;
    logic [31:0] salt;

    logic [31:0] w_addr, w_instr;
    logic        w_redirect_en, w_ready, w_valid;
    logic [31:0] w_redirect_pc, w_id_instr, w_id_pc, w_id_pc_plus4, w_fetch_cnt;

    int total = 0;
    int bad   = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000), .MEM_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_instr(mem_instr),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .fetch_cnt(fetch_cnt)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .MEM_WAIT(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .mem_addr(w_addr), .mem_instr(w_instr),
        .redirect_en(w_redirect_en), .redirect_pc(w_redirect_pc), .id_ready(w_ready),
        .id_valid(w_valid), .id_instr(w_id_instr), .id_pc(w_id_pc),
        .id_pc_plus4(w_id_pc_plus4), .fetch_cnt(w_fetch_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
        return (a >> 2) ^ s;
    endfunction

    assign mem_instr = mem_word(mem_addr, salt);
    assign w_instr   = mem_word(w_addr, 32'hA5A5_0000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        valid;
        logic [31:0] addr;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] fcnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic redir, input logic [31:0] rpc, input logic rdy,
                       input logic valid, input logic [31:0] addr, input logic [31:0] ipc,
                       input logic [31:0] instr, input logic [31:0] pc4, input logic [31:0] fcnt);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.valid = valid; v.addr = addr;
        v.ipc = ipc; v.instr = instr; v.pc4 = pc4; v.fcnt = fcnt;
        vecs.push_back(v);
    endtask

    // Behavioural model: age counts edges since the address last changed (unbounded).
    logic [31:0] m_pc, m_ipc, m_instr, m_pc4, m_fcnt;
    logic        m_valid;
    int unsigned m_age;

    task automatic model_edge();
        logic hs;
        hs = m_valid && id_ready;
        if (hs) m_fcnt = m_fcnt + 1;
        if (redirect_en) begin
            m_pc    = {redirect_pc[31:2], 2'b00};
            m_age   = 0;
            m_valid = 1'b0;
        end else if (m_age + 1 >= MW && (!m_valid || id_ready)) begin
            m_instr = mem_word(m_pc, salt);
            m_ipc   = m_pc;
            m_pc4   = m_pc + 4;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
            m_age   = 0;
        end else begin
            if (hs) m_valid = 1'b0;
            m_age++;
        end
    endtask

    task automatic check_model();
        chk("rnd_addr", mem_addr, m_pc);
        chk("rnd_valid", 32'(id_valid), 32'(m_valid));
        chk("rnd_fcnt", fetch_cnt, m_fcnt);
        if (m_valid) begin
            chk("rnd_pc", id_pc, m_ipc);
            chk("rnd_instr", id_instr, m_instr);
            chk("rnd_pc4", id_pc_plus4, m_pc4);
        end
    endtask

    initial begin
        rst_n = 1'b0; redirect_en = 1'b0; redirect_pc = '0; id_ready = 1'b1; salt = '0;
        w_redirect_en = 1'b0; w_redirect_pc = '0; w_ready = 1'b1;

        // Directed sequence: steady fetch, long stall, redirect, redirect with handshake.
        add(0, 0, 1, 0, 32'h0,   32'h0, 0, 32'h0, 0);
        add(0, 0, 1, 1, 32'h4,   32'h0, 0, 32'h4, 0);
        add(0, 0, 1, 0, 32'h4,   32'h0, 0, 32'h4, 1);
        add(0, 0, 1, 1, 32'h8,   32'h4, 1, 32'h8, 1);
        add(0, 0, 1, 0, 32'h8,   32'h4, 1, 32'h8, 2);
        add(0, 0, 1, 1, 32'hC,   32'h8, 2, 32'hC, 2);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 1, 32'hC, 32'h8, 2, 32'hC, 2);
        add(0, 0, 1, 1, 32'h10,  32'hC, 3, 32'h10, 3);
        add(1, 32'h103, 0, 0, 32'h100, 32'hC, 3, 32'h10, 3);
        add(0, 0, 1, 0, 32'h100, 32'hC, 3, 32'h10, 3);
        add(0, 0, 1, 1, 32'h104, 32'h100, 32'h40, 32'h104, 3);
        add(1, 32'h200, 1, 0, 32'h200, 32'h100, 32'h40, 32'h104, 4);
        add(0, 0, 1, 0, 32'h200, 32'h100, 32'h40, 32'h104, 4);
        add(0, 0, 1, 1, 32'h204, 32'h200, 32'h80, 32'h204, 4);

        repeat (3) @(negedge clk);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            redirect_en = vecs[k].redir;
            redirect_pc = vecs[k].rpc;
            id_ready    = vecs[k].rdy;
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", k), 32'(id_valid), 32'(vecs[k].valid));
            chk($sformatf("v%0d_addr", k), mem_addr, vecs[k].addr);
            chk($sformatf("v%0d_pc", k), id_pc, vecs[k].ipc);
            chk($sformatf("v%0d_instr", k), id_instr, vecs[k].instr);
            chk($sformatf("v%0d_pc4", k), id_pc_plus4, vecs[k].pc4);
            chk($sformatf("v%0d_fcnt", k), fetch_cnt, vecs[k].fcnt);
        end
        redirect_en = 1'b0;

        // Stall, then pull reset between edges: outputs must clear without a clock.
        id_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(id_valid), 32'h0);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_instr", id_instr, 32'h0);
        chk("arst_pc", id_pc, 32'h0);
        chk("arst_pc4", id_pc_plus4, 32'h0);
        chk("arst_fcnt", fetch_cnt, 32'h0);
        chk("arst_w_addr", w_addr, 32'hFFFF_FFFC);
        chk("arst_w_valid", 32'(w_valid), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        id_ready = 1'b1;
        m_pc = '0; m_ipc = '0; m_instr = '0; m_pc4 = '0; m_fcnt = '0;
        m_valid = 1'b0; m_age = 0;

        // First two edges double as the PC wrap check on the MEM_WAIT=1 instance.
        for (int n = 0; n < 400; n++) begin
            if (n >= 2) begin
                redirect_en = ($urandom_range(7) == 0);
                redirect_pc = $urandom;
                id_ready    = ($urandom_range(2) != 0);
                if ($urandom_range(15) == 0) salt = $urandom;
            end
            model_edge();
            @(posedge clk); #1;
            check_model();
            if (n == 0) begin
                chk("wrap_valid", 32'(w_valid), 32'h1);
                chk("wrap_pc", w_id_pc, 32'hFFFF_FFFC);
                chk("wrap_pc4", w_id_pc_plus4, 32'h0);
                chk("wrap_instr", w_id_instr, 32'hA5A5_0000 ^ 32'h3FFF_FFFF);
            end else if (n == 1) begin
                chk("wrap_next_pc", w_id_pc, 32'h0);
                chk("wrap_next_pc4", w_id_pc_plus4, 32'h4);
                chk("wrap_fcnt", w_fetch_cnt, 32'h1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
